// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
// Multiplexed 7-segment scan driver. Time-multiplexes NUM_DIGITS hex digits onto
// one shared set of segment lines. Each digit slot starts with a short blanked
// window (anti-ghosting), and PWM brightness gates the anode. All displayed
// values come from a shadow copy of the inputs, so a frame is never torn. That
// shadow copy is reloaded once per frame, on the frame's last cycle.
//
// Optional feature: define SEVENSEG_BLINK_EN to add per-digit blinking. This
// adds the i_blink port, the BLINK_FRAMES parameter, a frame counter and a
// blink phase. When the macro is undefined, none of that logic exists.
//
// Ports
//   i_clk          system clock
//   i_resetn       synchronous, active-low reset
//   i_data         hex nibble per digit, digit k = i_data[4k+3:4k]
//   i_enableDigit  1 = segments a-g shown for digit k
//   i_dots         decimal point for digit k
//   i_brightness   0 = dark, all-ones = full on
//   i_blink        per-digit blink enable (SEVENSEG_BLINK_EN only)
//   o_cathodes     {dp,g,f,e,d,c,b,a}, polarity set by CATHODE_ACTIVE_LOW
//   o_anodes       one-hot digit select, polarity set by ANODE_ACTIVE_LOW
//   o_frameStart   one-cycle pulse on the cycle after the shadow registers load
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS         = 8,
    parameter int DIGIT_PERIOD       = 4000,
    parameter int BLANK_CYCLES       = 16,
    parameter int PWM_BITS           = 4,
    parameter int ANODE_ACTIVE_LOW   = 1,
    parameter int CATHODE_ACTIVE_LOW = 1
`ifdef SEVENSEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES       = 64
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_resetn,
    input  logic [4*NUM_DIGITS-1:0]   i_data,
    input  logic [NUM_DIGITS-1:0]     i_enableDigit,
    input  logic [NUM_DIGITS-1:0]     i_dots,
    input  logic [PWM_BITS-1:0]       i_brightness,
`ifdef SEVENSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     i_blink,
`endif
    output logic [7:0]                o_cathodes,
    output logic [NUM_DIGITS-1:0]     o_anodes,
    output logic                      o_frameStart
);

    localparam int CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0]      BLANK_C   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            CATH_OFF  = (CATHODE_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // Active-high glyphs, bit order gfedcba.
    function automatic logic [6:0] f_font(input logic [3:0] nib);
        case (nib)
            4'h0: f_font = 7'h3F;  4'h1: f_font = 7'h06;
            4'h2: f_font = 7'h5B;  4'h3: f_font = 7'h4F;
            4'h4: f_font = 7'h66;  4'h5: f_font = 7'h6D;
            4'h6: f_font = 7'h7D;  4'h7: f_font = 7'h07;
            4'h8: f_font = 7'h7F;  4'h9: f_font = 7'h6F;
            4'hA: f_font = 7'h77;  4'hB: f_font = 7'h7C;
            4'hC: f_font = 7'h39;  4'hD: f_font = 7'h5E;
            4'hE: f_font = 7'h79;  default: f_font = 7'h71;
        endcase
    endfunction

    // Scan state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_primed;
    logic                    r_frame_start;
    logic [NUM_DIGITS-1:0]   r_anodes;
    logic [7:0]              r_cathodes;

    // Shadow copies of the inputs; everything on the pins derives from these.
    logic [4*NUM_DIGITS-1:0] r_sh_data;
    logic [NUM_DIGITS-1:0]   r_sh_en;
    logic [NUM_DIGITS-1:0]   r_sh_dots;
    logic [PWM_BITS-1:0]     r_sh_bri;

    logic [CNT_W-1:0]        w_cnt_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    w_load;
    logic                    w_gate;
    logic [PWM_BITS-1:0]     w_pwm_phase;
    logic [3:0]              w_nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_anode_hot;
    logic [NUM_DIGITS-1:0]   w_anodes_on;
    logic [7:0]              w_seg_on;
    logic [7:0]              w_cath_on;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nibbles[gi]   = r_sh_data[4*gi +: 4];
            assign w_anode_hot[gi] = (r_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        w_idx_next = r_idx;
        if (r_cnt == LAST_CNT) begin
            w_cnt_next = '0;
            w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // The first cycle after reset loads immediately, so the display never
    // scans a whole frame of zeroed shadow data.
    assign w_load = !r_primed || ((r_idx == LAST_IDX) && (r_cnt == LAST_CNT));

    // The PWM phase is the low bits of the slot counter. It is zero-extended
    // if the counter is narrower than PWM_BITS.
    assign w_pwm_phase = PWM_BITS'(r_cnt);
    assign w_gate      = (r_cnt >= BLANK_C) &&
                         ((r_sh_bri == '1) || (w_pwm_phase < r_sh_bri));

`ifdef SEVENSEG_BLINK_EN
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] r_sh_blink;
    logic [FCNT_W-1:0]     r_frame_cnt;
    logic                  r_blink_on;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sh_blink  <= '0;
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_load) begin
            r_sh_blink <= i_blink;
            if (r_frame_cnt == LAST_FRAME) begin
                r_frame_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        // A disabled digit loses a-g, but its decimal point stays visible.
        w_seg_on = {r_sh_dots[r_idx],
                    r_sh_en[r_idx] ? f_font(w_nibbles[r_idx]) : 7'h00};
`ifdef SEVENSEG_BLINK_EN
        // A blinking digit loses all segments; its anode timing is unchanged.
        if (r_sh_blink[r_idx] && !r_blink_on) begin
            w_seg_on = 8'h00;
        end
`endif
    end

    assign w_cath_on   = (CATHODE_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
    assign w_anodes_on = (ANODE_ACTIVE_LOW != 0) ? ~w_anode_hot : w_anode_hot;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_primed      <= 1'b0;
            r_frame_start <= 1'b0;
            r_sh_data     <= '0;
            r_sh_en       <= '0;
            r_sh_dots     <= '0;
            r_sh_bri      <= '0;
            r_anodes      <= ANODE_OFF;
            r_cathodes    <= CATH_OFF;
        end else begin
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_frame_start <= w_load;
            if (w_load) begin
                r_primed  <= 1'b1;
                r_sh_data <= i_data;
                r_sh_en   <= i_enableDigit;
                r_sh_dots <= i_dots;
                r_sh_bri  <= i_brightness;
            end
            r_anodes   <= w_gate ? w_anodes_on : ANODE_OFF;
            r_cathodes <= w_gate ? w_cath_on : CATH_OFF;
        end
    end

    assign o_anodes     = r_anodes;
    assign o_cathodes   = r_cathodes;
    assign o_frameStart = r_frame_start;

endmodule
